// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one data-memory word port between the CPU LSU (c) and
// the debug/loader port (d), with a one-cycle response path to the winning port.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DEPTH_WORDS  = 64,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           c_valid,
  output logic                           c_ready,
  input  logic                           c_we,
  input  logic [ADDR_W-1:0]              c_addr,
  input  logic [31:0]                    c_wdata,
  input  logic [3:0]                     c_wstrb,
  output logic                           c_rvalid,
  output logic [31:0]                    c_rdata,
  output logic                           c_err,
  input  logic                           d_valid,
  output logic                           d_ready,
  input  logic                           d_we,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic [31:0]                    d_wdata,
  input  logic [3:0]                     d_wstrb,
  output logic                           d_rvalid,
  output logic [31:0]                    d_rdata,
  output logic                           d_err,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
  output logic [31:0]                    mem_wdata,
  output logic [3:0]                     mem_wstrb,
  input  logic [31:0]                    mem_rdata
);

  localparam int MAW = $clog2(DEPTH_WORDS);
  localparam int SW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] WORD_LIM   = ADDR_W'(DEPTH_WORDS);

  logic              r_last_d;
  logic [SW-1:0]     r_starve;
  logic              r_c_rv;
  logic              r_d_rv;
  logic              r_rsp_err;
  logic              r_rsp_ld;
  logic [31:0]       r_c_rdata;
  logic [31:0]       r_d_rdata;

  logic              w_gnt_c;
  logic              w_gnt_d;
  logic              w_acc;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [3:0]        w_sel_wstrb;
  logic              w_in_range;
  logic [31:0]       w_rsp_data;

  // Grant: a lone requester always wins; a tie goes by mode (alternate, or CPU unless d is starved).
  always_comb begin
    w_gnt_c = 1'b0;
    w_gnt_d = 1'b0;
    if (!rst) begin
      if (c_valid && d_valid) begin
        if (ARB_MODE == 0) w_gnt_c = r_last_d;
        else               w_gnt_c = (r_starve != STARVE_MAX);
        w_gnt_d = !w_gnt_c;
      end else begin
        w_gnt_c = c_valid;
        w_gnt_d = d_valid;
      end
    end
  end

  assign c_ready = w_gnt_c;
  assign d_ready = w_gnt_d;
  assign w_acc   = w_gnt_c | w_gnt_d;

  assign w_sel_we    = w_gnt_d ? d_we    : c_we;
  assign w_sel_addr  = w_gnt_d ? d_addr  : c_addr;
  assign w_sel_wdata = w_gnt_d ? d_wdata : c_wdata;
  assign w_sel_wstrb = w_gnt_d ? d_wstrb : c_wstrb;
  assign w_in_range  = (w_sel_addr >> 2) < WORD_LIM;

  assign mem_en    = w_acc & w_in_range;
  assign mem_we    = w_acc & w_sel_we;
  assign mem_addr  = w_sel_addr[MAW+1:2];
  assign mem_wdata = w_sel_wdata;
  assign mem_wstrb = w_sel_we ? w_sel_wstrb : 4'b0000;

  // Response stage: memory read data lands this cycle; only in-range loads return it.
  assign w_rsp_data = r_rsp_ld ? mem_rdata : 32'h0;

  assign c_rvalid = r_c_rv & ~rst;
  assign d_rvalid = r_d_rv & ~rst;
  assign c_err    = r_c_rv & r_rsp_err & ~rst;
  assign d_err    = r_d_rv & r_rsp_err & ~rst;
  assign c_rdata  = rst ? 32'h0 : (r_c_rv ? w_rsp_data : r_c_rdata);
  assign d_rdata  = rst ? 32'h0 : (r_d_rv ? w_rsp_data : r_d_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d  <= 1'b1;
      r_starve  <= '0;
      r_c_rv    <= 1'b0;
      r_d_rv    <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_ld  <= 1'b0;
      r_c_rdata <= 32'h0;
      r_d_rdata <= 32'h0;
    end else begin
      r_c_rv    <= w_gnt_c;
      r_d_rv    <= w_gnt_d;
      r_rsp_err <= w_acc & ~w_in_range;
      r_rsp_ld  <= w_acc & w_in_range & ~w_sel_we;
      if (r_c_rv) r_c_rdata <= w_rsp_data;
      if (r_d_rv) r_d_rdata <= w_rsp_data;
      if (w_acc) begin
        r_last_d <= w_gnt_d;
        if ((ARB_MODE == 0) || w_gnt_d || !d_valid) r_starve <= '0;
        else if (r_starve != STARVE_MAX)            r_starve <= r_starve + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a CPU-priority instance share one stimulus
// stream; a transaction-level model checks every cycle, with literal expectations alongside.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_valid, c_we, d_valid, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_wstrb, d_wstrb;

  logic [1:0]  c_ready_v, d_ready_v, c_rvalid_v, d_rvalid_v, c_err_v, d_err_v;
  logic [1:0]  mem_en_v, mem_we_v;
  logic [31:0] c_rdata_v [2];
  logic [31:0] d_rdata_v [2];
  logic [5:0]  mem_addr_v [2];
  logic [31:0] mem_wdata_v [2];
  logic [3:0]  mem_wstrb_v [2];
  logic [31:0] mem_rdata_v [2];

  logic [31:0] tmem [2][64];
  logic        pl_en;
  logic [5:0]  pl_addr;
  logic [31:0] pl_data;

  int n_tot = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  bit rec_en = 1'b0;
  string dseq [2];
  string mseq [2];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DEPTH_WORDS(64), .ARB_MODE(0), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_ready(c_ready_v[0]), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_wstrb(c_wstrb), .c_rvalid(c_rvalid_v[0]), .c_rdata(c_rdata_v[0]),
    .c_err(c_err_v[0]),
    .d_valid(d_valid), .d_ready(d_ready_v[0]), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rvalid(d_rvalid_v[0]), .d_rdata(d_rdata_v[0]),
    .d_err(d_err_v[0]),
    .mem_en(mem_en_v[0]), .mem_we(mem_we_v[0]), .mem_addr(mem_addr_v[0]),
    .mem_wdata(mem_wdata_v[0]), .mem_wstrb(mem_wstrb_v[0]), .mem_rdata(mem_rdata_v[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DEPTH_WORDS(64), .ARB_MODE(1), .STARVE_LIMIT(4)) u_pr (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_ready(c_ready_v[1]), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_wstrb(c_wstrb), .c_rvalid(c_rvalid_v[1]), .c_rdata(c_rdata_v[1]),
    .c_err(c_err_v[1]),
    .d_valid(d_valid), .d_ready(d_ready_v[1]), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rvalid(d_rvalid_v[1]), .d_rdata(d_rdata_v[1]),
    .d_err(d_err_v[1]),
    .mem_en(mem_en_v[1]), .mem_we(mem_we_v[1]), .mem_addr(mem_addr_v[1]),
    .mem_wdata(mem_wdata_v[1]), .mem_wstrb(mem_wstrb_v[1]), .mem_rdata(mem_rdata_v[1])
  );

  // Synchronous memory array per instance, with a side door for preloading.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (pl_en) tmem[m][pl_addr] <= pl_data;
      else if (mem_en_v[m]) begin
        if (mem_we_v[m]) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb_v[m][b]) tmem[m][mem_addr_v[m]][8*b +: 8] <= mem_wdata_v[m][8*b +: 8];
        end else begin
          mem_rdata_v[m] <= tmem[m][mem_addr_v[m]];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got %s expected %s", name, act, exp);
  endtask

  // Model state: memory image, arbitration history and the one outstanding response.
  logic [31:0] img [2][64];
  bit          m_last_d [2];
  int          m_starve [2];
  bit          m_pc [2];
  bit          m_pd [2];
  bit          m_perr [2];
  logic [31:0] m_pdata [2];
  logic [31:0] m_hold_c [2];
  logic [31:0] m_hold_d [2];

  task automatic model_cycle(input int m);
    bit gc, gd, acc, inr, we;
    logic [31:0] a, wd;
    logic [3:0]  ws;
    string tag;
    tag = (m == 0) ? "rr" : "pr";
    if (rst) begin
      chk({tag, ".rst.c_ready"}, {31'b0, c_ready_v[m]}, 32'h0);
      chk({tag, ".rst.d_ready"}, {31'b0, d_ready_v[m]}, 32'h0);
      chk({tag, ".rst.c_rvalid"}, {31'b0, c_rvalid_v[m]}, 32'h0);
      chk({tag, ".rst.d_rvalid"}, {31'b0, d_rvalid_v[m]}, 32'h0);
      chk({tag, ".rst.c_err"}, {31'b0, c_err_v[m]}, 32'h0);
      chk({tag, ".rst.d_err"}, {31'b0, d_err_v[m]}, 32'h0);
      chk({tag, ".rst.c_rdata"}, c_rdata_v[m], 32'h0);
      chk({tag, ".rst.d_rdata"}, d_rdata_v[m], 32'h0);
      chk({tag, ".rst.mem_en"}, {31'b0, mem_en_v[m]}, 32'h0);
      m_pc[m] = 0; m_pd[m] = 0; m_perr[m] = 0; m_pdata[m] = 0;
      m_hold_c[m] = 0; m_hold_d[m] = 0; m_last_d[m] = 1; m_starve[m] = 0;
      return;
    end
    if (c_valid && d_valid) begin
      if (m == 0) gc = m_last_d[m];
      else        gc = (m_starve[m] != 4);
      gd = !gc;
    end else begin
      gc = c_valid;
      gd = d_valid;
    end
    acc = gc || gd;
    a   = gd ? d_addr  : c_addr;
    wd  = gd ? d_wdata : c_wdata;
    ws  = gd ? d_wstrb : c_wstrb;
    we  = gd ? d_we    : c_we;
    inr = (a / 4) < 64;
    chk({tag, ".c_ready"}, {31'b0, c_ready_v[m]}, {31'b0, gc});
    chk({tag, ".d_ready"}, {31'b0, d_ready_v[m]}, {31'b0, gd});
    chk({tag, ".mem_en"}, {31'b0, mem_en_v[m]}, {31'b0, acc && inr});
    if (acc && inr) begin
      chk({tag, ".mem_we"}, {31'b0, mem_we_v[m]}, {31'b0, we});
      chk({tag, ".mem_addr"}, {26'b0, mem_addr_v[m]}, (a / 4) % 64);
      if (we) chk({tag, ".mem_wdata"}, mem_wdata_v[m], wd);
      chk({tag, ".mem_wstrb"}, {28'b0, mem_wstrb_v[m]}, we ? {28'b0, ws} : 32'h0);
    end
    chk({tag, ".c_rvalid"}, {31'b0, c_rvalid_v[m]}, {31'b0, m_pc[m]});
    chk({tag, ".d_rvalid"}, {31'b0, d_rvalid_v[m]}, {31'b0, m_pd[m]});
    chk({tag, ".c_err"}, {31'b0, c_err_v[m]}, {31'b0, m_pc[m] && m_perr[m]});
    chk({tag, ".d_err"}, {31'b0, d_err_v[m]}, {31'b0, m_pd[m] && m_perr[m]});
    chk({tag, ".c_rdata"}, c_rdata_v[m], m_pc[m] ? m_pdata[m] : m_hold_c[m]);
    chk({tag, ".d_rdata"}, d_rdata_v[m], m_pd[m] ? m_pdata[m] : m_hold_d[m]);
    if (rec_en) begin
      if (gc) mseq[m] = {mseq[m], "C"};
      if (gd) mseq[m] = {mseq[m], "D"};
      if (c_ready_v[m] && c_valid) dseq[m] = {dseq[m], "C"};
      if (d_ready_v[m] && d_valid) dseq[m] = {dseq[m], "D"};
    end
    if (m_pc[m]) m_hold_c[m] = m_pdata[m];
    if (m_pd[m]) m_hold_d[m] = m_pdata[m];
    m_pc[m]   = gc;
    m_pd[m]   = gd;
    m_perr[m] = acc && !inr;
    m_pdata[m] = (acc && inr && !we) ? img[m][(a / 4) % 64] : 32'h0;
    if (acc && inr && we)
      for (int b = 0; b < 4; b++)
        if (ws[b]) img[m][(a / 4) % 64][8*b +: 8] = wd[8*b +: 8];
    if (acc) begin
      m_last_d[m] = gd;
      if (m == 0 || gd || !d_valid) m_starve[m] = 0;
      else if (m_starve[m] < 4)     m_starve[m] = m_starve[m] + 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en)
      for (int m = 0; m < 2; m++) model_cycle(m);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_valid = 0; d_valid = 0;
  endtask

  task automatic drive_c(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    c_valid = 1; c_we = we; c_addr = a; c_wdata = wd; c_wstrb = ws;
  endtask

  task automatic drive_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    d_valid = 1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    pl_en = 1; pl_addr = w[5:0]; pl_data = v;
    img[0][w] = v; img[1][w] = v;
    step();
    pl_en = 0;
  endtask

  initial begin
    rst = 1; pl_en = 0; pl_addr = 0; pl_data = 0;
    c_valid = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_wstrb = 0;
    d_valid = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    dseq[0] = ""; dseq[1] = ""; mseq[0] = ""; mseq[1] = "";
    step(); step();
    chk_en = 1;
    for (int w = 0; w < 64; w++) preload(w, 32'h0);
    preload(3, 32'hABCDEF11);
    preload(4, 32'hFFFFFFFF);
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk("lit.reset_c_ready", {31'b0, c_ready_v[m]}, 32'h0);
    step();
    rst = 0;

    // Single C load from word 3.
    drive_c(0, 32'd12, 32'h0, 4'h0);
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk("lit.t1_c_ready", {31'b0, c_ready_v[m]}, 32'h1);
    step(); idle();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("lit.t1_c_rvalid", {31'b0, c_rvalid_v[m]}, 32'h1);
      chk("lit.t1_c_rdata", c_rdata_v[m], 32'hABCDEF11);
      chk("lit.t1_c_err", {31'b0, c_err_v[m]}, 32'h0);
      chk("lit.t1_d_rvalid", {31'b0, d_rvalid_v[m]}, 32'h0);
    end
    step();

    // C store then D load of the same word on the next cycle.
    drive_c(1, 32'd16, 32'hABCDEF11, 4'hF);
    step(); idle();
    drive_d(0, 32'd16, 32'h0, 4'h0);
    step(); idle();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("lit.t2_d_rdata", d_rdata_v[m], 32'hABCDEF11);
      chk("lit.t2_mem4", tmem[m][4], 32'hABCDEF11);
    end
    step();

    // Partial-strobe store, zero-strobe store, then readback.
    drive_c(1, 32'd20, 32'h11223344, 4'b0101);
    step();
    drive_c(1, 32'd20, 32'hFFFFFFFF, 4'b0000);
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk("lit.strb0_mem_en", {31'b0, mem_en_v[m]}, 32'h1);
    step();
    drive_c(0, 32'd20, 32'h0, 4'h0);
    step(); idle();
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk("lit.strb_rdata", c_rdata_v[m], 32'h00220044);
    step();

    // Both ports requesting continuously from reset.
    rst = 1;
    step();
    rst = 0;
    drive_c(0, 32'd12, 32'h0, 4'h0);
    drive_d(0, 32'd16, 32'h0, 4'h0);
    rec_en = 1;
    repeat (10) step();
    rec_en = 0;
    idle();
    chk_str("lit.rr_order_dut", dseq[0], "CDCDCDCDCD");
    chk_str("lit.rr_order_model", mseq[0], "CDCDCDCDCD");
    chk_str("lit.pr_order_dut", dseq[1], "CCCCDCCCCD");
    chk_str("lit.pr_order_model", mseq[1], "CCCCDCCCCD");
    step();

    // Out-of-range D load.
    drive_d(0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk("lit.oor_mem_en", {31'b0, mem_en_v[m]}, 32'h0);
    step(); idle();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("lit.oor_d_rvalid", {31'b0, d_rvalid_v[m]}, 32'h1);
      chk("lit.oor_d_err", {31'b0, d_err_v[m]}, 32'h1);
      chk("lit.oor_d_rdata", d_rdata_v[m], 32'h0);
    end
    step();

    // Reset lands on the response cycle of a C load.
    drive_c(0, 32'd12, 32'h0, 4'h0);
    step(); idle();
    rst = 1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("lit.rstmid_c_rvalid", {31'b0, c_rvalid_v[m]}, 32'h0);
      chk("lit.rstmid_c_rdata", c_rdata_v[m], 32'h0);
      chk("lit.rstmid_mem_en", {31'b0, mem_en_v[m]}, 32'h0);
    end
    step();
    rst = 0;
    drive_c(0, 32'd0, 32'h0, 4'h0);
    drive_d(0, 32'd4, 32'h0, 4'h0);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("lit.post_rst_c_ready", {31'b0, c_ready_v[m]}, 32'h1);
      chk("lit.post_rst_d_ready", {31'b0, d_ready_v[m]}, 32'h0);
    end
    step(); idle();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
